// File: rtl/fddi_pkg.sv
// fddi_pkg: shared state encoding, timer width and frame-control codes for the FDDI claim/token path
package fddi_pkg;
  typedef enum logic [1:0] {
    RING_OP = 2'd0,
    CLAIM   = 2'd1,
    BEACON  = 2'd2,
    TOKEN   = 2'd3
  } state_t;
  localparam int T_W_DEF = 16;
  localparam logic [7:0] FC_TOKEN  = 8'h80;
  localparam logic [7:0] FC_CLAIM  = 8'hc3;
  localparam logic [7:0] FC_BEACON = 8'hc2;
  function automatic logic is_mac_frame(input logic [7:0] fc);
    return fc == FC_CLAIM || fc == FC_BEACON;
  endfunction
endpackage

// File: rtl/fddi_claim_ctrl_if.sv
// fddi_claim_ctrl_if: ring-event inputs and claim/token control outputs of the ring-access controller
interface fddi_claim_ctrl_if;
  import fddi_pkg::*;
  logic merge, er, xmit, fddi;
  logic rx_token, rx_claim_hi, rx_claim_own, rx_beacon_own;
  logic claim, tx_claim, tx_beacon, tx_token, xmit_grant, late;
  state_t state;
  modport master (
    output merge, er, xmit, fddi, rx_token, rx_claim_hi, rx_claim_own, rx_beacon_own,
    input  claim, tx_claim, tx_beacon, tx_token, xmit_grant, late, state
  );
  modport slave (
    input  merge, er, xmit, fddi, rx_token, rx_claim_hi, rx_claim_own, rx_beacon_own,
    output claim, tx_claim, tx_beacon, tx_token, xmit_grant, late, state
  );
endinterface

// File: rtl/fddi_timer.sv
// fddi_timer: up/down counter with clear, load, enable and optional saturation (clear beats load beats count)
module fddi_timer import fddi_pkg::*; #(
  parameter int W = T_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic         en,
  input  logic         up,
  input  logic         sat,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] q
);
  logic at_lim;
  assign at_lim = up ? &q : ~|q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (ld) q <= ld_val;
    else if (en && !(sat && at_lim)) q <= up ? q + 1'b1 : q - 1'b1;
endmodule

// File: rtl/fddi_claim_ctrl.sv
// fddi_claim_ctrl: FDDI ring-access controller; sequences claim/beacon/ring-op/token and owns TRT, THT, late and claim timeout
module fddi_claim_ctrl import fddi_pkg::*; #(
  parameter int T_W   = T_W_DEF,
  parameter int T_REQ = 8,
  parameter int T_MAX = 20
) (
  input logic clk,
  input logic rst_n,
  fddi_claim_ctrl_if.slave bus
);
  localparam logic [T_W-1:0] REQ_M1 = T_W'(T_REQ - 1);
  localparam logic [T_W-1:0] MAX_M1 = T_W'(T_MAX - 1);
  state_t st, st_nx;
  logic late, late_nx, tok_nx, tok_q, claim_q, beacon_q, grant_q, frc;
  logic trt_clr, trt_en, tht_clr, tht_ld, tht_en, ctm_clr, ctm_en;
  logic [T_W-1:0] trt, tht, ctm, tht_val;
  assign tht_val = trt >= REQ_M1 ? '0 : REQ_M1 - trt;
  fddi_timer #(.W(T_W)) u_trt (
    .clk(clk), .rst_n(rst_n), .clr(trt_clr), .ld(1'b0), .en(trt_en),
    .up(1'b1), .sat(1'b1), .ld_val('0), .q(trt)
  );
  fddi_timer #(.W(T_W)) u_tht (
    .clk(clk), .rst_n(rst_n), .clr(tht_clr), .ld(tht_ld), .en(tht_en),
    .up(1'b0), .sat(1'b1), .ld_val(tht_val), .q(tht)
  );
  fddi_timer #(.W(T_W)) u_ctm (
    .clk(clk), .rst_n(rst_n), .clr(ctm_clr), .ld(1'b0), .en(ctm_en),
    .up(1'b1), .sat(1'b1), .ld_val('0), .q(ctm)
  );
  always_comb begin
    st_nx   = st;
    late_nx = late;
    tok_nx  = 1'b0;
    frc     = 1'b1;
    trt_clr = 1'b0;
    trt_en  = 1'b0;
    tht_clr = 1'b0;
    tht_ld  = 1'b0;
    tht_en  = 1'b0;
    ctm_clr = 1'b0;
    ctm_en  = 1'b0;
    if (!bus.fddi) st_nx = BEACON;
    else if (bus.er && st != BEACON) st_nx = CLAIM;
    else if (bus.merge && (st == RING_OP || st == TOKEN)) st_nx = CLAIM;
    else begin
      frc = 1'b0;
      case (st)
        CLAIM: begin
          ctm_en = 1'b1;
          if (bus.rx_claim_own) begin
            st_nx  = RING_OP;
            tok_nx = 1'b1;
          end else if (bus.rx_claim_hi) st_nx = RING_OP;
          else if (ctm == MAX_M1) st_nx = BEACON;
        end
        RING_OP: begin
          // a token arriving in the expiry cycle takes precedence over the expiry
          if (bus.rx_token && bus.xmit && !late) begin
            st_nx   = TOKEN;
            tht_ld  = 1'b1;
            trt_clr = 1'b1;
          end else if (bus.rx_token) begin
            trt_clr = 1'b1;
            late_nx = 1'b0;
          end else if (trt >= REQ_M1) begin
            if (late) st_nx = CLAIM;
            else begin
              late_nx = 1'b1;
              trt_clr = 1'b1;
            end
          end else trt_en = 1'b1;
        end
        TOKEN: begin
          trt_en = 1'b1;
          if (!bus.xmit || tht == '0) begin
            st_nx  = RING_OP;
            tok_nx = 1'b1;
          end else tht_en = 1'b1;
        end
        default: if (bus.rx_beacon_own) st_nx = CLAIM;
      endcase
    end
    if (st_nx == BEACON || (st_nx == CLAIM && (frc || st != CLAIM))) begin
      trt_clr = 1'b1;
      ctm_clr = 1'b1;
      tht_clr = st_nx == BEACON;
      late_nx = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st       <= CLAIM;
      late     <= 1'b0;
      tok_q    <= 1'b0;
      claim_q  <= 1'b1;
      beacon_q <= 1'b0;
      grant_q  <= 1'b0;
    end else begin
      st       <= st_nx;
      late     <= late_nx;
      tok_q    <= tok_nx;
      claim_q  <= st_nx == CLAIM;
      beacon_q <= st_nx == BEACON;
      grant_q  <= st_nx == TOKEN;
    end
  assign bus.state      = st;
  assign bus.late       = late;
  assign bus.tx_token   = tok_q;
  assign bus.claim      = claim_q;
  assign bus.tx_claim   = claim_q;
  assign bus.tx_beacon  = beacon_q;
  assign bus.xmit_grant = grant_q;
endmodule

// File: tb/tb_fddi_claim_ctrl.sv
// tb_fddi_claim_ctrl: directed scenarios plus randomized ring events, checked every cycle against a behavioural model
module tb_fddi_claim_ctrl;
  import fddi_pkg::*;
  localparam int T_REQ = 8;
  localparam int T_MAX = 20;
  typedef struct {
    int st;
    int trt;
    int tht;
    int ctm;
    bit late;
    bit tok;
  } mdl_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int pass = 0;
  int total = 0;
  mdl_t m;
  fddi_claim_ctrl_if bus();
  fddi_claim_ctrl #(.T_W(16), .T_REQ(T_REQ), .T_MAX(T_MAX)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic void chk(string name, int act, int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction
  function automatic mdl_t rst_m();
    mdl_t r;
    r.st = 1; r.trt = 0; r.tht = 0; r.ctm = 0; r.late = 0; r.tok = 0;
    return r;
  endfunction
  function automatic mdl_t enter(mdl_t x, int s);
    x.st = s; x.trt = 0; x.ctm = 0; x.late = 0;
    if (s == 2) x.tht = 0;
    return x;
  endfunction
  function automatic mdl_t step(mdl_t x);
    mdl_t n = x;
    n.tok = 0;
    if (!bus.fddi) return enter(n, 2);
    if (bus.er && x.st != 2) return enter(n, 1);
    if (bus.merge && (x.st == 0 || x.st == 3)) return enter(n, 1);
    case (x.st)
      1: if (bus.rx_claim_own) begin n.st = 0; n.tok = 1; end
         else if (bus.rx_claim_hi) n.st = 0;
         else if (x.ctm == T_MAX - 1) n = enter(n, 2);
         else n.ctm++;
      0: if (bus.rx_token && bus.xmit && !x.late) begin
           n.st = 3;
           n.tht = x.trt >= T_REQ - 1 ? 0 : T_REQ - 1 - x.trt;
           n.trt = 0;
         end else if (bus.rx_token) begin n.trt = 0; n.late = 0; end
         else if (x.trt >= T_REQ - 1) begin
           if (x.late) n = enter(n, 1);
           else begin n.late = 1; n.trt = 0; end
         end else n.trt++;
      3: begin
           n.trt = x.trt < 65535 ? x.trt + 1 : x.trt;
           if (!bus.xmit || x.tht == 0) begin n.st = 0; n.tok = 1; end
           else n.tht--;
         end
      default: if (bus.rx_beacon_own) n = enter(n, 1);
    endcase
    return n;
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m <= rst_m();
    else m <= step(m);
  always @(negedge clk)
    if (rst_n) begin
      chk("state", bus.state, m.st);
      chk("claim", bus.claim, m.st == 1);
      chk("tx_claim", bus.tx_claim, m.st == 1);
      chk("tx_beacon", bus.tx_beacon, m.st == 2);
      chk("xmit_grant", bus.xmit_grant, m.st == 3);
      chk("tx_token", bus.tx_token, m.tok);
      chk("late", bus.late, m.late);
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n;
    {bus.merge, bus.er, bus.xmit, bus.rx_token, bus.rx_claim_hi, bus.rx_claim_own, bus.rx_beacon_own} = '0;
    bus.fddi = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_state", bus.state, 1);
    chk("rst_claim", bus.claim, 1);
    chk("rst_tx_claim", bus.tx_claim, 1);
    chk("rst_tx_beacon", bus.tx_beacon, 0);
    chk("rst_tx_token", bus.tx_token, 0);
    chk("rst_grant", bus.xmit_grant, 0);
    chk("rst_late", bus.late, 0);
    tick(); tick(); tick();
    chk("claim_c3", bus.state, 1);
    bus.rx_claim_own = 1; tick(); bus.rx_claim_own = 0;
    chk("won_state", bus.state, 0);
    chk("won_tok", bus.tx_token, 1);
    tick();
    chk("won_tok_off", bus.tx_token, 0);
    tick(); tick();
    bus.xmit = 1; bus.rx_token = 1; tick(); bus.rx_token = 0;
    chk("cap_state", bus.state, 3);
    n = 0;
    while (bus.xmit_grant && n < 20) begin n++; tick(); end
    chk("grant_len", n, 5);
    chk("rel_tok", bus.tx_token, 1);
    chk("rel_state", bus.state, 0);
    bus.xmit = 0;
    bus.er = 1; tick(); bus.er = 0;
    chk("er_claim", bus.state, 1);
    bus.rx_claim_hi = 1; tick(); bus.rx_claim_hi = 0;
    chk("yield_state", bus.state, 0);
    chk("yield_tok", bus.tx_token, 0);
    n = 0;
    while (!bus.late && n < 40) begin n++; tick(); end
    chk("late_at", n, 8);
    while (bus.state != CLAIM && n < 40) begin n++; tick(); end
    chk("reclaim_at", n, 16);
    chk("reclaim_late", bus.late, 0);
    bus.rx_claim_hi = 1; tick(); bus.rx_claim_hi = 0;
    repeat (8) tick();
    chk("late_set", bus.late, 1);
    bus.xmit = 1; bus.rx_token = 1; tick(); bus.rx_token = 0;
    chk("late_tok_state", bus.state, 0);
    chk("late_tok_grant", bus.xmit_grant, 0);
    chk("late_tok_late", bus.late, 0);
    bus.er = 1; bus.rx_token = 1; tick(); bus.er = 0; bus.rx_token = 0;
    chk("er_vs_tok", bus.state, 1);
    bus.rx_claim_hi = 1; tick(); bus.rx_claim_hi = 0;
    bus.rx_token = 1; tick(); bus.rx_token = 0;
    chk("tok2_state", bus.state, 3);
    tick();
    bus.fddi = 0; tick(); bus.fddi = 1;
    chk("down_state", bus.state, 2);
    chk("down_grant", bus.xmit_grant, 0);
    chk("down_tok", bus.tx_token, 0);
    chk("down_beacon", bus.tx_beacon, 1);
    bus.xmit = 0;
    bus.rx_beacon_own = 1; tick(); bus.rx_beacon_own = 0;
    chk("beacon_back", bus.state, 1);
    n = 0;
    while (bus.state != BEACON && n < 40) begin n++; tick(); end
    chk("timeout_at", n, 20);
    chk("timeout_beacon", bus.tx_beacon, 1);
    bus.rx_claim_own = 1; bus.rx_token = 1; tick(); bus.rx_claim_own = 0; bus.rx_token = 0;
    chk("beacon_ignores", bus.state, 2);
    bus.rx_beacon_own = 1; tick(); bus.rx_beacon_own = 0;
    n = 0;
    while (bus.state != BEACON && n < 40) begin n++; tick(); end
    chk("timeout_again", n, 20);
    bus.rx_beacon_own = 1; tick(); bus.rx_beacon_own = 0;
    bus.rx_claim_own = 1; tick(); bus.rx_claim_own = 0;
    bus.xmit = 1; bus.rx_token = 1; tick(); bus.rx_token = 0;
    chk("pre_rst_state", bus.state, 3);
    #2 rst_n = 0;
    #1;
    chk("arst_state", bus.state, 1);
    chk("arst_claim", bus.claim, 1);
    chk("arst_tx_claim", bus.tx_claim, 1);
    chk("arst_grant", bus.xmit_grant, 0);
    chk("arst_tok", bus.tx_token, 0);
    chk("arst_beacon", bus.tx_beacon, 0);
    chk("arst_late", bus.late, 0);
    @(posedge clk);
    #1 rst_n = 1;
    bus.xmit = 0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 1500; i++) begin
        bus.fddi          = $urandom_range(63) != 0;
        bus.er            = $urandom_range(99) == 0;
        bus.merge         = $urandom_range(99) == 0;
        if ($urandom_range(7) == 0) bus.xmit = ~bus.xmit;
        bus.rx_token      = $urandom_range(p == 0 ? 3 : 19) == 0;
        bus.rx_claim_hi   = $urandom_range(15) == 0;
        bus.rx_claim_own  = $urandom_range(15) == 0;
        bus.rx_beacon_own = $urandom_range(7) == 0;
        tick();
      end
    {bus.merge, bus.er, bus.rx_token, bus.rx_claim_hi, bus.rx_claim_own, bus.rx_beacon_own} = '0;
    tick(); tick();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
